// File: rtl/prog_ctr_seq.sv
// Fetch-stage program counter that launches program slots through a Start handshake.
// It supports relative/absolute branches, call/return through a link stack, and halt/done status.
module prog_ctr_seq #(
    parameter int A           = 10,
    parameter int NPROG       = 3,
    parameter int PROG_STRIDE = 100,
    parameter int DEPTH       = 4,
    localparam int PW         = (NPROG > 1) ? $clog2(NPROG) : 1
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Halt,
    input  logic          Stall,
    input  logic          Branch,
    input  logic          AbsMode,
    input  logic          Call,
    input  logic          Ret,
    input  logic [A-1:0]  Target,
    output logic [A-1:0]  ProgCtr,
    output logic [PW-1:0] ProgNum,
    output logic          Running,
    output logic          Done,
    output logic          StackErr
);

    localparam int SW = $clog2(DEPTH + 1);
    localparam int SN = 1 << SW;

    typedef enum logic [1:0] {IDLE, ARMED, RUN, HALTED} state_t;

    state_t          state, state_n;
    logic [A-1:0]    pc, pc_n;
    logic [PW-1:0]   prog_num, prog_num_n;
    logic [PW-1:0]   next_slot, next_slot_n;
    logic            done, done_n;
    logic            stack_err, stack_err_n;
    logic [SW-1:0]   sp, sp_n;
    logic            start_q;
    logic            push;
    logic [A-1:0]    stack [SN];

    logic            start_rise;
    logic [A-1:0]    jump;
    logic [A-1:0]    pc_inc;
    logic [A-1:0]    slot_base;
    logic [SW-1:0]   top_idx;
    logic            stack_empty;
    logic            stack_full;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            pc        <= '0;
            prog_num  <= '0;
            next_slot <= '0;
            done      <= 1'b0;
            stack_err <= 1'b0;
            sp        <= '0;
            start_q   <= 1'b0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            prog_num  <= prog_num_n;
            next_slot <= next_slot_n;
            done      <= done_n;
            stack_err <= stack_err_n;
            sp        <= sp_n;
            start_q   <= Start;
        end
    end

    // Return addresses are written at the current stack pointer on a successful push.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < SN; i++) begin
                stack[i] <= '0;
            end
        end else if (push) begin
            stack[sp] <= pc_inc;
        end
    end

    always_comb begin
        start_rise  = Start && !start_q;
        pc_inc      = pc + A'(1);
        jump        = AbsMode ? Target : pc + Target;
        slot_base   = A'(32'(next_slot) * 32'(PROG_STRIDE));
        top_idx     = sp - SW'(1);
        stack_empty = (sp == '0);
        stack_full  = (sp == SW'(DEPTH));

        state_n     = state;
        pc_n        = pc;
        prog_num_n  = prog_num;
        next_slot_n = next_slot;
        done_n      = done;
        stack_err_n = stack_err;
        sp_n        = sp;
        push        = 1'b0;

        case (state)
            IDLE, HALTED: begin
                if (start_rise) begin
                    state_n = ARMED;
                end
            end
            ARMED: begin
                if (!Start) begin
                    state_n     = RUN;
                    pc_n        = slot_base;
                    prog_num_n  = next_slot;
                    next_slot_n = (next_slot == PW'(NPROG - 1)) ? '0 : next_slot + PW'(1);
                    done_n      = 1'b0;
                    stack_err_n = 1'b0;
                    sp_n        = '0;
                end
            end
            RUN: begin
                // Strict priority: abort, halt, stall, return, call, branch, increment.
                if (start_rise) begin
                    state_n = ARMED;
                end else if (Halt) begin
                    state_n = HALTED;
                    done_n  = 1'b1;
                end else if (Stall) begin
                    pc_n = pc;
                end else if (Ret) begin
                    if (!stack_empty) begin
                        pc_n = stack[top_idx];
                        sp_n = top_idx;
                    end else begin
                        stack_err_n = 1'b1;
                        pc_n        = pc_inc;
                    end
                end else if (Call) begin
                    pc_n = jump;
                    if (!stack_full) begin
                        push = 1'b1;
                        sp_n = sp + SW'(1);
                    end else begin
                        stack_err_n = 1'b1;
                    end
                end else if (Branch) begin
                    pc_n = jump;
                end else begin
                    pc_n = pc_inc;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign ProgCtr  = pc;
    assign ProgNum  = prog_num;
    assign Running  = (state == RUN);
    assign Done     = done;
    assign StackErr = stack_err;

endmodule

// File: tb/tb_prog_ctr_seq.sv
// Self-checking bench for prog_ctr_seq: a queue-based reference model is compared every cycle,
// and directed literal checks are applied at each step of the launch/branch/call scenario.
module tb_prog_ctr_seq;

    localparam int A      = 10;
    localparam int NPROG  = 3;
    localparam int STRIDE = 100;
    localparam int DEPTH  = 4;
    localparam int MOD    = 1 << A;
    localparam int PW     = (NPROG > 1) ? $clog2(NPROG) : 1;

    logic          Clk = 1'b0;
    logic          Reset = 1'b0;
    logic          Start = 1'b0;
    logic          Halt = 1'b0;
    logic          Stall = 1'b0;
    logic          Branch = 1'b0;
    logic          AbsMode = 1'b0;
    logic          Call = 1'b0;
    logic          Ret = 1'b0;
    logic [A-1:0]  Target = '0;
    logic [A-1:0]  ProgCtr;
    logic [PW-1:0] ProgNum;
    logic          Running;
    logic          Done;
    logic          StackErr;

    int passCount  = 0;
    int checkCount = 0;

    prog_ctr_seq #(
        .A(A), .NPROG(NPROG), .PROG_STRIDE(STRIDE), .DEPTH(DEPTH)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt), .Stall(Stall),
        .Branch(Branch), .AbsMode(AbsMode), .Call(Call), .Ret(Ret), .Target(Target),
        .ProgCtr(ProgCtr), .ProgNum(ProgNum), .Running(Running), .Done(Done),
        .StackErr(StackErr)
    );

    initial begin
        forever #5 Clk = ~Clk;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference model: phases 0=idle 1=armed 2=run 3=halted, link stack held as a queue.
    int mPhase, mPc, mProg, mSlot, mDone, mErr, mStartPrev, mDest, mOff;
    int mStack[$];

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            mPhase = 0; mPc = 0; mProg = 0; mSlot = 0;
            mDone = 0; mErr = 0; mStartPrev = 0;
            mStack.delete();
        end else begin
            mOff  = (int'(Target) >= MOD / 2) ? int'(Target) - MOD : int'(Target);
            mDest = AbsMode ? int'(Target) : (((mPc + mOff) % MOD) + MOD) % MOD;
            if (mPhase == 0 || mPhase == 3) begin
                if (Start && !mStartPrev) mPhase = 1;
            end else if (mPhase == 1) begin
                if (!Start) begin
                    mPhase = 2;
                    mPc    = (mSlot * STRIDE) % MOD;
                    mProg  = mSlot;
                    mSlot  = (mSlot + 1) % NPROG;
                    mDone  = 0;
                    mErr   = 0;
                    mStack.delete();
                end
            end else begin
                if (Start && !mStartPrev) begin
                    mPhase = 1;
                end else if (Halt) begin
                    mPhase = 3;
                    mDone  = 1;
                end else if (Stall) begin
                    mPc = mPc;
                end else if (Ret) begin
                    if (mStack.size() > 0) begin
                        mPc = mStack.pop_back();
                    end else begin
                        mErr = 1;
                        mPc  = (mPc + 1) % MOD;
                    end
                end else if (Call) begin
                    if (mStack.size() < DEPTH) mStack.push_back((mPc + 1) % MOD);
                    else mErr = 1;
                    mPc = mDest;
                end else if (Branch) begin
                    mPc = mDest;
                end else begin
                    mPc = (mPc + 1) % MOD;
                end
            end
            mStartPrev = int'(Start);
        end
    end

    always @(negedge Clk) begin
        checkOutput("model ProgCtr", int'(ProgCtr), mPc);
        checkOutput("model ProgNum", int'(ProgNum), mProg);
        checkOutput("model Running", int'(Running), (mPhase == 2) ? 1 : 0);
        checkOutput("model Done", int'(Done), mDone);
        checkOutput("model StackErr", int'(StackErr), mErr);
    end

    task automatic applyStimulus(input logic st, input logic ht, input logic sl, input logic br,
                                 input logic ab, input logic ca, input logic re,
                                 input logic [A-1:0] tg);
        Start = st; Halt = ht; Stall = sl; Branch = br;
        AbsMode = ab; Call = ca; Ret = re; Target = tg;
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, '0);
    endtask

    task automatic launch();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, '0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, '0);
    endtask

    task automatic jumpAbs(input int t);
        applyStimulus(0, 0, 0, 1, 1, 0, 0, A'(t));
    endtask

    task automatic callAbs(input int t);
        applyStimulus(0, 0, 0, 0, 1, 1, 0, A'(t));
    endtask

    task automatic ret();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, '0);
    endtask

    initial begin
        #1 Reset = 1'b1;
        #2;
        checkOutput("reset pc", int'(ProgCtr), 0);
        checkOutput("reset running", int'(Running), 0);
        checkOutput("reset done", int'(Done), 0);
        #9 Reset = 1'b0;
        @(posedge Clk); #1;

        applyStimulus(1, 0, 0, 0, 0, 0, 0, '0);
        checkOutput("armed running", int'(Running), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, '0);
        checkOutput("launch0 pc", int'(ProgCtr), 0);
        checkOutput("launch0 prog", int'(ProgNum), 0);
        checkOutput("launch0 running", int'(Running), 1);
        idle(5);
        checkOutput("increment pc", int'(ProgCtr), 5);

        applyStimulus(0, 1, 0, 0, 0, 0, 0, '0);
        checkOutput("halt done", int'(Done), 1);
        checkOutput("halt pc", int'(ProgCtr), 5);
        jumpAbs(77);
        checkOutput("halted ignores branch", int'(ProgCtr), 5);
        launch();
        checkOutput("launch1 pc", int'(ProgCtr), 100);
        checkOutput("launch1 prog", int'(ProgNum), 1);
        checkOutput("launch1 done", int'(Done), 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, '0);
        launch();
        checkOutput("launch2 pc", int'(ProgCtr), 200);
        checkOutput("launch2 prog", int'(ProgNum), 2);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, '0);
        launch();
        checkOutput("wrap pc", int'(ProgCtr), 0);
        checkOutput("wrap prog", int'(ProgNum), 0);

        jumpAbs(10);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 10'h3FD);
        checkOutput("rel branch -3", int'(ProgCtr), 7);
        jumpAbs(300);
        checkOutput("abs branch", int'(ProgCtr), 300);
        jumpAbs(1023);
        idle(1);
        checkOutput("pc wrap", int'(ProgCtr), 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, '0);
        checkOutput("stall hold", int'(ProgCtr), 0);

        jumpAbs(20);
        callAbs(50);
        checkOutput("call jump", int'(ProgCtr), 50);
        idle(2);
        ret();
        checkOutput("ret pc", int'(ProgCtr), 21);
        callAbs(100); callAbs(200); callAbs(300); callAbs(400);
        checkOutput("four calls no err", int'(StackErr), 0);
        callAbs(500);
        checkOutput("overflow jump", int'(ProgCtr), 500);
        checkOutput("overflow err", int'(StackErr), 1);
        ret();
        checkOutput("pop top", int'(ProgCtr), 301);
        ret(); ret(); ret();
        checkOutput("pop bottom", int'(ProgCtr), 22);

        launch();
        checkOutput("relaunch clears err", int'(StackErr), 0);
        ret();
        checkOutput("underflow err", int'(StackErr), 1);
        checkOutput("underflow pc", int'(ProgCtr), 101);

        launch();
        jumpAbs(8);
        applyStimulus(0, 0, 1, 1, 1, 1, 0, A'(60));
        checkOutput("stall beats jumps", int'(ProgCtr), 8);
        checkOutput("stall no err", int'(StackErr), 0);
        applyStimulus(0, 0, 0, 1, 1, 1, 1, A'(60));
        checkOutput("ret priority pc", int'(ProgCtr), 9);
        checkOutput("ret priority err", int'(StackErr), 1);

        applyStimulus(1, 0, 0, 0, 0, 0, 0, '0);
        checkOutput("abort pc", int'(ProgCtr), 9);
        checkOutput("abort running", int'(Running), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, '0);
        checkOutput("after abort prog", int'(ProgNum), 0);
        jumpAbs(40);
        checkOutput("pre-reset pc", int'(ProgCtr), 40);
        #2 Reset = 1'b1;
        #1;
        checkOutput("async reset pc", int'(ProgCtr), 0);
        checkOutput("async reset running", int'(Running), 0);
        #2 Reset = 1'b0;
        @(posedge Clk); #1;
        launch();
        checkOutput("post-reset slot", int'(ProgNum), 0);
        checkOutput("post-reset pc", int'(ProgCtr), 0);
        idle(2);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/prog_ctr_seq.md
Name: prog_ctr_seq

Overview:
Parametrised successor to the processor's program counter. It sequences multiple test-bench programs through a Start handshake, with one launch per program slot. It supports relative or absolute branches and call/return through a small link stack, and it reports halt and done status. It sits in the fetch stage, drives the instruction-memory address and takes decoded control from the decoder.

Parameters:
A, 10, instruction-address width in bits
NPROG, 3, number of program slots (≥1)
PROG_STRIDE, 100, base address of slot k is k*PROG_STRIDE, truncated to A bits
DEPTH, 4, link-stack entries (≥1)

Ports:
Clk  in  1  clock; all state changes on posedge
Reset  in  1  asynchronous, active-high; clears all state
Start  in  1  program-launch request from test bench (level; see handshake)
Halt  in  1  decoded halt instruction
Stall  in  1  hold PC this cycle
Branch  in  1  take branch
AbsMode  in  1  1: Target is absolute; 0: Target is signed relative offset
Call  in  1  push return address, then jump
Ret  in  1  pop return address, then jump to it
Target  in  A  branch/call target or offset (two's complement when relative)
ProgCtr  out  A  program counter (instruction-memory address)
ProgNum  out  $clog2(NPROG) (min 1)  slot index of the current or last launched program
Running  out  1  high while in RUN
Done  out  1  high in HALTED until the next launch
StackErr  out  1  sticky: link-stack overflow or underflow since the last launch

Behaviour:
- Reset (async, any state, mid-operation included): ProgCtr=0, ProgNum=0, state=IDLE, Running=0, Done=0, StackErr=0, stack pointer=0, next-slot=0, Start history register=0.
- States: IDLE, ARMED, RUN, HALTED. Running = (state==RUN).
- Start edge detection: a rising edge is Start=1 with the registered Start=0. The registered Start updates every cycle.
- IDLE/HALTED: on a Start rising edge, go to ARMED. ProgCtr and Done hold.
- ARMED: hold everything while Start=1.
- ARMED, on Start=0 (falling edge): go to RUN and launch the program:
  - ProgCtr <= next_slot*PROG_STRIDE.
  - ProgNum <= next_slot.
  - next_slot <= (next_slot+1) mod NPROG, so slots wrap after NPROG launches.
  - Done <= 0, StackErr <= 0, stack pointer <= 0.
- RUN, evaluated each cycle. Priority, first match wins:
  1. Start rising edge: abort to ARMED; ProgCtr holds.
  2. Halt: go to HALTED; Done <= 1; ProgCtr holds.
  3. Stall: all state holds.
  4. Ret:
     - Stack non-empty: pop; ProgCtr <= popped value.
     - Stack empty: StackErr <= 1; ProgCtr <= ProgCtr+1.
  5. Call:
     - Stack not full: push ProgCtr+1 (mod 2^A); ProgCtr <= jump target.
     - Stack full (DEPTH entries): StackErr <= 1; no push; jump still taken.
  6. Branch: ProgCtr <= jump target.
  7. Otherwise: ProgCtr <= ProgCtr+1.
- Jump target:
  - AbsMode=1: Target.
  - AbsMode=0: ProgCtr + Target, with Target signed, result mod 2^A.
- Arithmetic: all PC arithmetic is A bits and wraps; 2^A-1 increments to 0.
- Simultaneous controls resolve strictly by the priority list: Ret beats Call, Call beats Branch, Stall beats all jumps.
- Control inputs other than Start are ignored outside RUN.
- Latency: every PC update is visible on ProgCtr the cycle after the qualifying posedge. No combinational path from inputs to outputs.

Test Plan:
- Reset then Start pulse (1 high cycle) -> ARMED for 1 cycle; after the falling edge, ProgCtr=0, ProgNum=0, Running=1; increments 0,1,2,...
- Halt at PC=5, then second Start pulse -> Done=1 with PC=5 held; after launch, ProgCtr=100, ProgNum=1, Done=0. Third launch -> 200, ProgNum=2; fourth launch wraps to ProgCtr=0, ProgNum=0.
- At PC=10, relative branch with Target=-3 (A=10: 10'h3FD) -> ProgCtr=7. Absolute branch with Target=300 -> ProgCtr=300. At PC=1023, plain increment -> ProgCtr=0.
- Call at PC=20 (abs Target=50), run to 52, Ret -> ProgCtr 50,51,52,21. Five nested calls with DEPTH=4 -> fifth call still jumps, StackErr=1. Ret on an empty stack -> StackErr=1, ProgCtr+1.
- Stall+Branch+Call asserted together at PC=8 -> ProgCtr stays 8; the next cycle with Ret+Call+Branch (stack empty) -> StackErr=1, ProgCtr=9.
- Async Reset asserted mid-cycle in RUN at PC=40 -> outputs clear immediately, without waiting for a clock edge. Start rising edge in RUN -> ARMED, PC holds, Running=0.
